// File: rtl/utils_pkg.sv
// Shared core-bus types and constants used by the CB read arbiter and its routing queue.
package utils_pkg;

  typedef logic cb_arb_id_t;
  localparam cb_arb_id_t CB_M0 = 1'b0;
  localparam cb_arb_id_t CB_M1 = 1'b1;

  localparam logic [1:0] CB_OKAY   = 2'b00;
  localparam logic [1:0] CB_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;
    logic        rd_addr_valid;
    logic        rd_ready;
    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic        wr_addr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        wr_data_valid;
    logic        wr_resp_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        rd_addr_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_valid;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    logic [1:0]  wr_resp;
    logic        wr_resp_valid;
  } s_cb_miso_t;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with occupancy output; writes when full and reads when empty are dropped.
module fifo #(
  parameter int SLOTS = 4,
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         write_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         read_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(SLOTS+1)-1:0]   ocup_o
);
  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(SLOTS - 1);

  logic [WIDTH-1:0] mem_q [SLOTS];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_wr, do_rd;

  assign full_o  = (cnt_q == CNT_W'(SLOTS));
  assign empty_o = (cnt_q == '0);
  assign do_wr   = write_i && !full_o;
  assign do_rd   = read_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign ocup_o  = cnt_q;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/cb_rd_arbiter.sv
// Two-master CB read arbiter with in-order response routing; writes pass through from M1.
// Define CB_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority, M1 over M0).
module cb_rd_arbiter
  import utils_pkg::*;
#(
  parameter int MAX_OT_TXN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  s_cb_mosi_t m0_cb_mosi_i,
  output s_cb_miso_t m0_cb_miso_o,
  input  s_cb_mosi_t m1_cb_mosi_i,
  output s_cb_miso_t m1_cb_miso_o,
  output s_cb_mosi_t s_cb_mosi_o,
  input  s_cb_miso_t s_cb_miso_i
);
  localparam int CNT_W = $clog2(MAX_OT_TXN + 1);

  logic [CNT_W-1:0] ot_cnt;
  logic             lock_q, lock_d;
  cb_arb_id_t       lock_id_q, lock_id_d;
  cb_arb_id_t       grant, head_id;
  logic             m0_v, m1_v, q_full, q_empty;
  logic             rd_addr_valid, push, pop, head_rd_ready;
  logic             m0_head, m1_head;
  logic [31:0]      gr_addr;
  logic [2:0]       gr_size;
  logic             unused_q_full, unused_m0_mosi;

  assign m0_v          = m0_cb_mosi_i.rd_addr_valid;
  assign m1_v          = m1_cb_mosi_i.rd_addr_valid;
  assign q_full        = (ot_cnt == CNT_W'(MAX_OT_TXN));
  assign rd_addr_valid = (m0_v || m1_v) && !q_full;
  assign push          = rd_addr_valid && s_cb_miso_i.rd_addr_ready;
  assign m0_head       = !q_empty && (head_id == CB_M0);
  assign m1_head       = !q_empty && (head_id == CB_M1);
  assign head_rd_ready = (m0_head && m0_cb_mosi_i.rd_ready) || (m1_head && m1_cb_mosi_i.rd_ready);
  assign pop           = s_cb_miso_i.rd_valid && head_rd_ready;
  assign gr_addr       = (grant == CB_M1) ? m1_cb_mosi_i.rd_addr : m0_cb_mosi_i.rd_addr;
  assign gr_size       = (grant == CB_M1) ? m1_cb_mosi_i.rd_size : m0_cb_mosi_i.rd_size;
  assign unused_m0_mosi = ^m0_cb_mosi_i;

`ifdef CB_ARB_ROUND_ROBIN_EN
  cb_arb_id_t last_grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last_grant_q <= CB_M1;
    else if (push) last_grant_q <= grant;
  end
`endif

  // A stalled request keeps its grant so the slave sees a stable address until accepted.
  always_comb begin
    if (lock_q && ((lock_id_q == CB_M1) ? m1_v : m0_v)) grant = lock_id_q;
`ifdef CB_ARB_ROUND_ROBIN_EN
    else if (m0_v && m1_v) grant = ~last_grant_q;
`endif
    else grant = m1_v ? CB_M1 : CB_M0;
  end

  assign lock_d    = rd_addr_valid && !s_cb_miso_i.rd_addr_ready;
  assign lock_id_d = grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= CB_M1;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Routing queue: one entry per accepted read, holding the issuing master's ID.
  fifo #(
    .SLOTS (MAX_OT_TXN),
    .WIDTH (1)
  ) u_route_q (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .write_i (push),
    .data_i  (grant),
    .read_i  (pop),
    .data_o  (head_id),
    .full_o  (unused_q_full),
    .empty_o (q_empty),
    .ocup_o  (ot_cnt)
  );

  always_comb begin
    s_cb_mosi_o               = m1_cb_mosi_i;
    s_cb_mosi_o.rd_addr       = rd_addr_valid ? gr_addr : '0;
    s_cb_mosi_o.rd_size       = rd_addr_valid ? gr_size : '0;
    s_cb_mosi_o.rd_addr_valid = rd_addr_valid;
    s_cb_mosi_o.rd_ready      = head_rd_ready;
  end

  always_comb begin
    m1_cb_miso_o               = s_cb_miso_i;
    m1_cb_miso_o.rd_addr_ready = rd_addr_valid && (grant == CB_M1) && s_cb_miso_i.rd_addr_ready;
    m1_cb_miso_o.rd_valid      = m1_head && s_cb_miso_i.rd_valid;
    m1_cb_miso_o.rd_data       = m1_head ? s_cb_miso_i.rd_data : '0;
    m1_cb_miso_o.rd_resp       = m1_head ? s_cb_miso_i.rd_resp : CB_OKAY;

    m0_cb_miso_o               = '0;
    m0_cb_miso_o.rd_addr_ready = rd_addr_valid && (grant == CB_M0) && s_cb_miso_i.rd_addr_ready;
    m0_cb_miso_o.rd_valid      = m0_head && s_cb_miso_i.rd_valid;
    m0_cb_miso_o.rd_data       = m0_head ? s_cb_miso_i.rd_data : '0;
    m0_cb_miso_o.rd_resp       = m0_head ? s_cb_miso_i.rd_resp : CB_OKAY;
  end

endmodule

// File: tb/tb_cb_rd_arbiter.sv
// Randomized scoreboard bench for cb_rd_arbiter: per-master expected-response queues plus a
// rule-level model of grant, outstanding limit and routing, checked every cycle.
module tb_cb_rd_arbiter;
  import utils_pkg::*;

  localparam int MAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  s_cb_mosi_t m0_mosi, m1_mosi, s_mosi;
  s_cb_miso_t m0_miso, m1_miso, s_miso;

  cb_rd_arbiter #(.MAX_OT_TXN(MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_cb_mosi_i (m0_mosi),
    .m0_cb_miso_o (m0_miso),
    .m1_cb_mosi_i (m1_mosi),
    .m1_cb_miso_o (m1_miso),
    .s_cb_mosi_o  (s_mosi),
    .s_cb_miso_i  (s_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Stimulus knobs (percent probabilities)
  int p_req [2];
  int p_rrdy [2];
  int p_srdy;
  int p_resp;
  bit hold_rst = 1'b1;

  // Master and slave stimulus state
  bit          pend [2];
  logic [31:0] req_addr [2];
  logic [2:0]  req_size [2];
  logic [31:0] slave_q [$];
  bit          resp_hold;

  // Scoreboard: expected {resp, data} per master in issue order
  logic [33:0] exp_q0 [$];
  logic [33:0] exp_q1 [$];

  // Reference model state
  int mdl_route [$];
  int lock_m;
`ifdef CB_ARB_ROUND_ROBIN_EN
  int last_m;
`endif

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [1:0] resp_fn(input logic [31:0] a);
    return (a[5:2] == 4'hB) ? CB_SLVERR : CB_OKAY;
  endfunction

  function automatic bit rnd(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic s_cb_mosi_t make_mosi(input int m);
    s_cb_mosi_t r;
    r               = '0;
    r.rd_addr       = req_addr[m];
    r.rd_size       = req_size[m];
    r.rd_addr_valid = pend[m];
    r.rd_ready      = rnd(p_rrdy[m]);
    r.wr_addr       = $urandom();
    r.wr_size       = 3'($urandom_range(7));
    r.wr_addr_valid = 1'($urandom_range(1));
    r.wr_data       = $urandom();
    r.wr_strobe     = 4'($urandom_range(15));
    r.wr_data_valid = 1'($urandom_range(1));
    r.wr_resp_ready = 1'($urandom_range(1));
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("%0t FAIL %s: got %0h expected %0h", $time, name, act, exp);
    end
  endtask

  task automatic score(input int m, input logic v, input logic r, input logic [31:0] d,
                       input logic [1:0] rs);
    logic [33:0] e;
    if (v && r) begin
      if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
        n_checks++;
        n_err++;
        $display("%0t FAIL m%0d_unexpected_rsp: got data %h resp %0d expected no response",
                 $time, m, d, rs);
      end else begin
        e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        $display("%0t m%0d rsp data=%h resp=%0d", $time, m, d, rs);
        check($sformatf("m%0d_rsp", m), 128'({rs, d}), 128'(e));
      end
    end
  endtask

  // Drives every DUT input on the falling edge and records handshakes that will complete.
  initial begin : stim
    rst       = 1'b0;
    m0_mosi   = '0;
    m1_mosi   = '0;
    s_miso    = '0;
    resp_hold = 1'b0;
    forever begin
      @(negedge clk);
      rst = !hold_rst;
      if (hold_rst) begin
        pend[0]   = 1'b0;
        pend[1]   = 1'b0;
        resp_hold = 1'b0;
        slave_q.delete();
        exp_q0.delete();
        exp_q1.delete();
        m0_mosi = '0;
        m1_mosi = '0;
        s_miso  = '0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (!pend[m] && rnd(p_req[m])) begin
            pend[m]     = 1'b1;
            req_addr[m] = $urandom() & 32'hFFFF_FFFC;
            req_size[m] = 3'($urandom_range(2));
          end
        end
        m0_mosi = make_mosi(0);
        m1_mosi = make_mosi(1);
        s_miso               = '0;
        s_miso.rd_addr_ready = rnd(p_srdy);
        if (slave_q.size() > 0 && (resp_hold || rnd(p_resp))) begin
          s_miso.rd_valid = 1'b1;
          s_miso.rd_data  = data_fn(slave_q[0]);
          s_miso.rd_resp  = resp_fn(slave_q[0]);
        end
        s_miso.wr_addr_ready = 1'($urandom_range(1));
        s_miso.wr_data_ready = 1'($urandom_range(1));
        s_miso.wr_resp       = 2'($urandom_range(3));
        s_miso.wr_resp_valid = 1'($urandom_range(1));
        #1;
        if (m0_mosi.rd_addr_valid && m0_miso.rd_addr_ready) begin
          exp_q0.push_back({resp_fn(req_addr[0]), data_fn(req_addr[0])});
          $display("%0t m0 req addr=%h", $time, req_addr[0]);
          pend[0] = 1'b0;
        end
        if (m1_mosi.rd_addr_valid && m1_miso.rd_addr_ready) begin
          exp_q1.push_back({resp_fn(req_addr[1]), data_fn(req_addr[1])});
          $display("%0t m1 req addr=%h", $time, req_addr[1]);
          pend[1] = 1'b0;
        end
        if (s_miso.rd_valid && s_mosi.rd_ready) begin
          void'(slave_q.pop_front());
          resp_hold = 1'b0;
        end else begin
          resp_hold = s_miso.rd_valid;
        end
        if (s_mosi.rd_addr_valid && s_miso.rd_addr_ready) slave_q.push_back(s_mosi.rd_addr);
      end
    end
  end

  // Monitor: scoreboard pops plus rule checks, sampled mid-low-phase.
  initial begin : mon
    int  g, h;
    bit  v0, v1, exp_sv, pop_m, push_m;
    lock_m = -1;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("rst_outputs", 128'({m0_miso.rd_valid, m0_miso.rd_addr_ready, m1_miso.rd_valid,
                                   m1_miso.rd_addr_ready, s_mosi.rd_addr_valid, s_mosi.rd_ready,
                                   s_mosi.rd_addr, s_mosi.rd_size}), 128'(0));
        mdl_route.delete();
        lock_m = -1;
`ifdef CB_ARB_ROUND_ROBIN_EN
        last_m = 1;
`endif
      end else begin
        score(0, m0_miso.rd_valid, m0_mosi.rd_ready, m0_miso.rd_data, m0_miso.rd_resp);
        score(1, m1_miso.rd_valid, m1_mosi.rd_ready, m1_miso.rd_data, m1_miso.rd_resp);

        v0 = m0_mosi.rd_addr_valid;
        v1 = m1_mosi.rd_addr_valid;
        if (lock_m >= 0 && ((lock_m == 1) ? v1 : v0)) g = lock_m;
`ifdef CB_ARB_ROUND_ROBIN_EN
        else if (v0 && v1) g = 1 - last_m;
`endif
        else g = v1 ? 1 : 0;
        exp_sv = (v0 || v1) && (mdl_route.size() < MAX);

        check("s_rd_addr_valid", 128'(s_mosi.rd_addr_valid), 128'(exp_sv));
        if (exp_sv) begin
          check("s_rd_addr", 128'({s_mosi.rd_addr, s_mosi.rd_size}),
                128'((g == 1) ? {m1_mosi.rd_addr, m1_mosi.rd_size}
                              : {m0_mosi.rd_addr, m0_mosi.rd_size}));
          check("m0_rd_addr_ready", 128'(m0_miso.rd_addr_ready),
                128'((g == 0) && s_miso.rd_addr_ready));
          check("m1_rd_addr_ready", 128'(m1_miso.rd_addr_ready),
                128'((g == 1) && s_miso.rd_addr_ready));
        end else begin
          check("rd_addr_ready_blocked", 128'({m0_miso.rd_addr_ready, m1_miso.rd_addr_ready}),
                128'(0));
        end

        pop_m = 1'b0;
        if (mdl_route.size() > 0) begin
          h = mdl_route[0];
          check("s_rd_ready", 128'(s_mosi.rd_ready),
                128'((h == 1) ? m1_mosi.rd_ready : m0_mosi.rd_ready));
          check("head_rd_valid", 128'((h == 1) ? m1_miso.rd_valid : m0_miso.rd_valid),
                128'(s_miso.rd_valid));
          check("other_rd_valid", 128'((h == 1) ? m0_miso.rd_valid : m1_miso.rd_valid),
                128'(0));
          pop_m = s_miso.rd_valid && ((h == 1) ? m1_mosi.rd_ready : m0_mosi.rd_ready);
        end else begin
          check("idle_rd", 128'({s_mosi.rd_ready, m0_miso.rd_valid, m1_miso.rd_valid}),
                128'(0));
        end

        check("wr_fwd", 128'({s_mosi.wr_addr, s_mosi.wr_size, s_mosi.wr_addr_valid,
                              s_mosi.wr_data, s_mosi.wr_strobe, s_mosi.wr_data_valid,
                              s_mosi.wr_resp_ready}),
              128'({m1_mosi.wr_addr, m1_mosi.wr_size, m1_mosi.wr_addr_valid,
                    m1_mosi.wr_data, m1_mosi.wr_strobe, m1_mosi.wr_data_valid,
                    m1_mosi.wr_resp_ready}));
        check("m1_wr_rsp", 128'({m1_miso.wr_addr_ready, m1_miso.wr_data_ready,
                                 m1_miso.wr_resp, m1_miso.wr_resp_valid}),
              128'({s_miso.wr_addr_ready, s_miso.wr_data_ready,
                    s_miso.wr_resp, s_miso.wr_resp_valid}));
        check("m0_wr_rsp", 128'({m0_miso.wr_addr_ready, m0_miso.wr_data_ready,
                                 m0_miso.wr_resp, m0_miso.wr_resp_valid}), 128'(0));

        push_m = exp_sv && s_miso.rd_addr_ready;
        if (pop_m) void'(mdl_route.pop_front());
        if (push_m) begin
          mdl_route.push_back(g);
`ifdef CB_ARB_ROUND_ROBIN_EN
          last_m = g;
`endif
        end
        lock_m = (exp_sv && !s_miso.rd_addr_ready) ? g : -1;
      end
    end
  end

  task automatic phase(input int r0, input int r1, input int rr0, input int rr1,
                       input int srdy, input int resp, input int cycles);
    p_req[0]  = r0;
    p_req[1]  = r1;
    p_rrdy[0] = rr0;
    p_rrdy[1] = rr1;
    p_srdy    = srdy;
    p_resp    = resp;
    repeat (cycles) @(posedge clk);
  endtask

  initial begin : main
    p_req[0] = 0; p_req[1] = 0; p_rrdy[0] = 0; p_rrdy[1] = 0; p_srdy = 0; p_resp = 0;
    hold_rst = 1'b1;
    repeat (4) @(posedge clk);
    hold_rst = 1'b0;
    phase( 60,   0, 100, 100, 100,  70,  60);  // M0 only, slave always ready
    phase(100, 100, 100, 100, 100, 100,  60);  // both masters always requesting
    phase( 80,  80,  90,  90,  30,  60, 150);  // frequent address stalls (grant lock)
    phase(100, 100, 100, 100, 100,   0,  20);  // responses withheld: fill to MAX
    phase(100, 100, 100,  20, 100,  60, 100);  // M1 rarely accepts responses
    phase(100, 100, 100, 100, 100,   0,  20);  // fill again, then reset mid-operation
    hold_rst = 1'b1;
    repeat (3) @(posedge clk);
    hold_rst = 1'b0;
    phase( 50,  50,  60,  60,  60,  50, 400);  // mixed random traffic
    phase(  0,   0, 100, 100, 100, 100,  60);  // drain
    check("m0_drained", 128'(exp_q0.size()), 128'(0));
    check("m1_drained", 128'(exp_q1.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
